// File: rtl/dmux8_dispatch_ctrl_pkg.sv
// Shared channel constants and types for the round-robin byte dispatcher.
// Channel indices match the bit positions of en_mask/out_valid/out_ready.
package dmux8_dispatch_ctrl_pkg;

    localparam int unsigned DMUX_CH_W = 0;
    localparam int unsigned DMUX_CH_X = 1;
    localparam int unsigned DMUX_CH_Y = 2;
    localparam int unsigned DMUX_CH_Z = 3;
    localparam int unsigned DMUX_NCH  = 4;

    typedef enum logic [1:0] {
        CH_W = 2'd0,
        CH_X = 2'd1,
        CH_Y = 2'd2,
        CH_Z = 2'd3
    } dmux_ch_e;

endpackage

// File: rtl/dmux8_1to4b.sv
// 8-bit 1-to-4 demultiplexer: A appears on the output chosen by Sel, others read 0.
import dmux8_dispatch_ctrl_pkg::*;

module dmux8_1to4b (
    output logic [7:0] W,
    output logic [7:0] X,
    output logic [7:0] Y,
    output logic [7:0] Z,
    input  logic [7:0] A,
    input  logic [1:0] Sel
);

    always_comb begin
        W = '0;
        X = '0;
        Y = '0;
        Z = '0;
        case (dmux_ch_e'(Sel))
            CH_W:    W = A;
            CH_X:    X = A;
            CH_Y:    Y = A;
            default: Z = A;
        endcase
    end

endmodule

// File: rtl/dmux8_dispatch_ctrl.sv
// Round-robin dispatcher: one-entry byte buffer shared among four sinks via a demux,
// with a per-byte stall timeout that drops bytes a dead sink never accepts.
import dmux8_dispatch_ctrl_pkg::*;

module dmux8_dispatch_ctrl #(
    parameter int unsigned STALL_MAX = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [3:0]       en_mask,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [7:0]       W,
    output logic [7:0]       X,
    output logic [7:0]       Y,
    output logic [7:0]       Z,
    output logic [1:0]       sel,
    output logic             drop,
    output logic [CNT_W-1:0] drop_cnt
);

    // Counter only needs to reach STALL_MAX-1; the timeout fires on that value.
    localparam int unsigned SW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
    localparam logic [SW-1:0] STALL_LAST = SW'((STALL_MAX > 0) ? (STALL_MAX - 1) : 0);

    logic             r_full;
    logic [7:0]       r_data;
    logic [1:0]       r_tgt;
    logic [1:0]       r_last;
    logic [SW-1:0]    r_stall_cnt;
    logic             r_drop;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_fire_out;
    logic             w_fire_in;
    logic             w_in_ready;
    logic             w_stalled;
    logic             w_timeout;
    logic [1:0]       w_rr_last;
    logic [1:0]       w_new_tgt;

    // First enabled channel in order last+1, last+2, last+3, last.
    function automatic logic [1:0] next_tgt(input logic [1:0] last, input logic [3:0] en);
        logic [1:0] c;
        next_tgt = last;
        for (int unsigned k = DMUX_NCH; k >= 1; k--) begin
            c = last + 2'(k);
            if (en[c]) next_tgt = c;
        end
    endfunction

    assign w_fire_out = r_full & out_ready[r_tgt];
    assign w_in_ready = (en_mask != '0) & (~r_full | w_fire_out) & ~r_drop;
    assign w_fire_in  = in_valid & w_in_ready;
    assign w_stalled  = r_full & ~out_ready[r_tgt];
    assign w_timeout  = (STALL_MAX != 0) && w_stalled && (r_stall_cnt == STALL_LAST);

    // A byte loaded in the same cycle as a delivery sees the channel just served.
    assign w_rr_last  = w_fire_out ? r_tgt : r_last;
    assign w_new_tgt  = next_tgt(w_rr_last, en_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_full      <= 1'b0;
            r_data      <= '0;
            r_tgt       <= '0;
            r_last      <= 2'd3;
            r_stall_cnt <= '0;
            r_drop      <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_drop <= w_timeout;

            // Data is cleared when the buffer empties so the demux outputs read 0.
            if (w_fire_in) begin
                r_full <= 1'b1;
                r_data <= in_data;
                r_tgt  <= w_new_tgt;
            end else if (w_fire_out || w_timeout) begin
                r_full <= 1'b0;
                r_data <= '0;
            end

            if (w_fire_out || w_timeout)
                r_last <= r_tgt;

            if (w_fire_in || w_fire_out || w_timeout)
                r_stall_cnt <= '0;
            else if (w_stalled && (STALL_MAX != 0))
                r_stall_cnt <= r_stall_cnt + 1'b1;

            if (w_timeout && (r_drop_cnt != '1))
                r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    dmux8_1to4b u_dmux (
        .W   (W),
        .X   (X),
        .Y   (Y),
        .Z   (Z),
        .A   (r_data),
        .Sel (r_tgt)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = r_full ? (4'b0001 << r_tgt) : 4'b0000;
    assign sel       = r_tgt;
    assign drop      = r_drop;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_dmux8_dispatch_ctrl.sv
// Directed bench for the round-robin dispatcher with hand-computed expectations.
module tb_dmux8_dispatch_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [3:0] en_mask;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] W, X, Y, Z;
    logic [1:0] sel;
    logic       drop;
    logic [7:0] drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmux8_dispatch_ctrl #(.STALL_MAX(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .en_mask   (en_mask),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .W         (W),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .sel       (sel),
        .drop      (drop),
        .drop_cnt  (drop_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected {W,X,Y,Z} packed as one 32-bit word.
    task automatic chk_out(input string tag, input logic [3:0] ov, input logic [31:0] wxyz);
        chk({tag, "_ov"}, {28'd0, out_valid}, {28'd0, ov});
        chk({tag, "_wxyz"}, {W, X, Y, Z}, wxyz);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        en_mask = 4'hF; out_ready = 4'hF;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk_out("rst", 4'h0, 32'h0);
        chk("rst_sel", {30'd0, sel}, 32'd0);
        chk("rst_dcnt", {24'd0, drop_cnt}, 32'd0);
        chk("rst_drop", {31'd0, drop}, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);

        // 1: all enabled, back to back A1..A4 -> W,X,Y,Z
        in_valid = 1'b1; in_data = 8'hA1; #1;
        chk("t1_rdy0", {31'd0, in_ready}, 32'd1);
        tick(); in_data = 8'hA2; #1;
        chk_out("t1_a1", 4'b0001, 32'hA1000000);
        chk("t1_rdy1", {31'd0, in_ready}, 32'd1);
        tick(); in_data = 8'hA3; #1;
        chk_out("t1_a2", 4'b0010, 32'h00A20000);
        chk("t1_sel", {30'd0, sel}, 32'd1);
        tick(); in_data = 8'hA4; #1;
        chk_out("t1_a3", 4'b0100, 32'h0000A300);
        chk("t1_rdy3", {31'd0, in_ready}, 32'd1);
        tick(); in_valid = 1'b0; #1;
        chk_out("t1_a4", 4'b1000, 32'h000000A4);
        tick();
        chk_out("t1_idle", 4'h0, 32'h0);

        // 2: only W and Y enabled -> W,Y,W,Y
        en_mask = 4'b0101; in_valid = 1'b1; in_data = 8'h10;
        tick(); in_data = 8'h11; #1;
        chk_out("t2_10", 4'b0001, 32'h10000000);
        tick(); in_data = 8'h12; #1;
        chk_out("t2_11", 4'b0100, 32'h00001100);
        tick(); in_data = 8'h13; #1;
        chk_out("t2_12", 4'b0001, 32'h12000000);
        tick(); in_valid = 1'b0; #1;
        chk_out("t2_13", 4'b0100, 32'h00001300);
        tick();
        chk_out("t2_idle", 4'h0, 32'h0);

        // 3: 5A to X, X not ready for 3 cycles, delivered on the 4th
        en_mask = 4'b0010; out_ready = 4'b1101; in_valid = 1'b1; in_data = 8'h5A;
        tick(); in_data = 8'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_out("t3_hold", 4'b0010, 32'h005A0000);
            chk("t3_rdy", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 4'hF; in_valid = 1'b0; #1;
        chk_out("t3_deliv", 4'b0010, 32'h005A0000);
        tick();
        chk_out("t3_done", 4'h0, 32'h0);
        chk("t3_drop", {31'd0, drop}, 32'd0);
        chk("t3_dcnt", {24'd0, drop_cnt}, 32'd0);

        // 4: Y never ready, dropped after 4 offered cycles; next byte goes to Z
        en_mask = 4'hF; out_ready = 4'b1011; in_valid = 1'b1; in_data = 8'h66;
        tick(); in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_out("t4_hold", 4'b0100, 32'h00006600);
            chk("t4_nodrop", {31'd0, drop}, 32'd0);
            tick();
        end
        in_valid = 1'b1; in_data = 8'h88; #1;
        chk_out("t4_empty", 4'h0, 32'h0);
        chk("t4_drop", {31'd0, drop}, 32'd1);
        chk("t4_dcnt", {24'd0, drop_cnt}, 32'd1);
        chk("t4_rdy_drop", {31'd0, in_ready}, 32'd0);
        tick();
        chk("t4_drop_end", {31'd0, drop}, 32'd0);
        chk("t4_rdy_after", {31'd0, in_ready}, 32'd1);
        tick(); in_valid = 1'b0; #1;
        chk_out("t4_z", 4'b1000, 32'h00000088);
        chk("t4_dcnt_keep", {24'd0, drop_cnt}, 32'd1);
        tick();
        chk_out("t4_idle", 4'h0, 32'h0);

        // 5: nothing enabled -> never ready, nothing offered
        en_mask = 4'b0000; in_valid = 1'b1; in_data = 8'h99;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_rdy", {31'd0, in_ready}, 32'd0);
            chk_out("t5_out", 4'h0, 32'h0);
            tick();
        end

        // 6: reset while holding C3 for Z; first byte after reset goes to W
        en_mask = 4'b1000; out_ready = 4'b0111; in_data = 8'hC3;
        tick(); in_valid = 1'b0; #1;
        chk_out("t6_hold", 4'b1000, 32'h000000C3);
        rst = 1'b1;
        tick(); #1;
        chk_out("t6_rst", 4'h0, 32'h0);
        chk("t6_dcnt", {24'd0, drop_cnt}, 32'd0);
        chk("t6_sel", {30'd0, sel}, 32'd0);
        rst = 1'b0; en_mask = 4'hF; out_ready = 4'hF; in_valid = 1'b1; in_data = 8'hD4;
        tick(); in_valid = 1'b0; #1;
        chk_out("t6_w", 4'b0001, 32'hD4000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
